// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus bit-serial shifts
// (one bit per cycle) with registered result and O/C/S/Z flags.
module ula_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESU,
  output logic             out_valid,
  output logic             O,
  output logic             C,
  output logic             S,
  output logic             Z
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic                    accept;
  logic                    is_shift;
  logic                    shift_start;
  logic                    last_step;
  logic [SHW-1:0]          k;

  logic signed [WIDTH-1:0] x, y;
  logic                    cin;
  logic [WIDTH:0]          sum;
  logic                    arith, lgc;
  logic [WIDTH-1:0]        alu_res;
  logic                    upd_o, upd_c, upd_s, upd_z;

  logic [WIDTH-1:0]        shreg;
  logic [SHW-1:0]          cnt;
  logic                    asr_mode;
  logic [WIDTH:0]          step;

  // Signed overflow: operands agree in sign, result disagrees.
  function automatic logic ovf(input logic signed [WIDTH-1:0] a,
                               input logic signed [WIDTH-1:0] b,
                               input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // One shift step; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                            input logic asr);
    if (asr) return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
    return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
  endfunction

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign k           = B[SHW-1:0];
  assign is_shift    = (OP == 5'b01000) || (OP == 5'b01001);
  assign shift_start = accept && is_shift && (k != '0);
  assign last_step   = (state == SHIFT) && (cnt == SHW'(1));
  assign step        = shift1(shreg, asr_mode);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (shift_start) state_nxt = SHIFT;
      SHIFT: if (last_step)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle datapath; subtraction uses A + ~B (+1), decrement A + all-ones.
  always_comb begin
    x       = A;
    y       = '0;
    cin     = 1'b0;
    arith   = 1'b0;
    lgc     = 1'b0;
    alu_res = '0;
    upd_o   = 1'b0;
    upd_c   = 1'b0;
    upd_s   = 1'b0;
    upd_z   = 1'b0;
    case (OP)
      5'b00000: begin y = B;                arith = 1'b1; end
      5'b00001: begin y = B;  cin = 1'b1;   arith = 1'b1; end
      5'b00011: begin         cin = 1'b1;   arith = 1'b1; end
      5'b00100: begin y = ~B;               arith = 1'b1; end
      5'b00101: begin y = ~B; cin = 1'b1;   arith = 1'b1; end
      5'b00110: begin y = '1;               arith = 1'b1; end
      5'b01000,
      5'b01001: begin alu_res = A; upd_s = 1'b1; upd_z = 1'b1; end
      5'b10000: begin alu_res = '0; upd_z = 1'b1; end
      5'b10001: begin alu_res = A & B;     lgc = 1'b1; end
      5'b10010: begin alu_res = ~A & B;    lgc = 1'b1; end
      5'b10011: alu_res = B;
      5'b10100: begin alu_res = A & ~B;    lgc = 1'b1; end
      5'b10101: begin alu_res = A;         lgc = 1'b1; end
      5'b10110: begin alu_res = A ^ B;     lgc = 1'b1; end
      5'b10111: begin alu_res = A | B;     lgc = 1'b1; end
      5'b11000: begin alu_res = ~A & ~B;   lgc = 1'b1; end
      5'b11001: begin alu_res = ~(A ^ B);  lgc = 1'b1; end
      5'b11010: begin alu_res = ~A;        lgc = 1'b1; end
      5'b11011: begin alu_res = ~A | B;    lgc = 1'b1; end
      5'b11100: begin alu_res = ~B;        lgc = 1'b1; end
      5'b11101: begin alu_res = A | ~B;    lgc = 1'b1; end
      5'b11110: begin alu_res = ~A | ~B;   lgc = 1'b1; end
      5'b11111: alu_res = '1;
      default:  alu_res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
    if (arith) begin
      alu_res = sum[WIDTH-1:0];
      upd_o   = 1'b1;
      upd_c   = 1'b1;
      upd_s   = 1'b1;
      upd_z   = 1'b1;
    end
    if (lgc) begin
      upd_s = 1'b1;
      upd_z = 1'b1;
    end
  end

  // Shift working registers; meaningful only while in SHIFT.
  always_ff @(posedge clk) begin
    if (shift_start) begin
      shreg    <= A;
      cnt      <= k;
      asr_mode <= OP[0];
    end else if (state == SHIFT) begin
      shreg <= step[WIDTH-1:0];
      cnt   <= cnt - SHW'(1);
    end
  end

  // Registered result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      RESU      <= '0;
      out_valid <= 1'b0;
      O         <= 1'b0;
      C         <= 1'b0;
      S         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (last_step) begin
        RESU      <= step[WIDTH-1:0];
        C         <= step[WIDTH];
        S         <= step[WIDTH-1];
        Z         <= ~|step[WIDTH-1:0];
        out_valid <= 1'b1;
      end else if (accept && !shift_start) begin
        RESU      <= alu_res;
        out_valid <= 1'b1;
        if (upd_o) O <= ovf(x, y, alu_res);
        if (upd_c) C <= sum[WIDTH];
        if (upd_s) S <= alu_res[WIDTH-1];
        if (upd_z) Z <= ~|alu_res;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: directed scenarios plus random ops checked
// against an integer-arithmetic reference model.
module tb_ula_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, O, C, S, Z;
  logic [4:0]   OP;
  logic [W-1:0] A, B, RESU;

  int vectors = 0;
  int miscompares = 0;

  logic m_o = 1'b0, m_c = 1'b0, m_s = 1'b0, m_z = 1'b0;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .OP(OP), .A(A), .B(B), .RESU(RESU), .out_valid(out_valid),
    .O(O), .C(C), .S(S), .Z(Z)
  );

  always #5 clk = ~clk;

  // Reference: result, latency and flag evolution from the opcode table.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output int lat);
    logic [W-1:0] y;
    int cin, k;
    longint u, sv;
    bit arith, lgc;
    y = '0; cin = 0; arith = 0; lgc = 0; r = '0; lat = 1;
    case (op)
      5'b00000: begin y = b;  cin = 0; arith = 1; end
      5'b00001: begin y = b;  cin = 1; arith = 1; end
      5'b00011: begin y = 0;  cin = 1; arith = 1; end
      5'b00100: begin y = ~b; cin = 0; arith = 1; end
      5'b00101: begin y = ~b; cin = 1; arith = 1; end
      5'b00110: begin y = '1; cin = 0; arith = 1; end
      5'b01000, 5'b01001: begin
        k = int'(b[3:0]);
        lat = k + 1;
        if (k == 0) r = a;
        else if (op == 5'b01000) begin
          r = W'(longint'(a) << k);
          m_c = a[W-k];
        end else begin
          r = W'($signed(a) >>> k);
          m_c = a[k-1];
        end
        m_s = r[W-1];
        m_z = (r == 0);
      end
      5'b10000: begin r = '0; m_z = 1'b1; end
      5'b10001: begin r = a & b;    lgc = 1; end
      5'b10010: begin r = ~a & b;   lgc = 1; end
      5'b10011: r = b;
      5'b10100: begin r = a & ~b;   lgc = 1; end
      5'b10101: begin r = a;        lgc = 1; end
      5'b10110: begin r = a ^ b;    lgc = 1; end
      5'b10111: begin r = a | b;    lgc = 1; end
      5'b11000: begin r = ~a & ~b;  lgc = 1; end
      5'b11001: begin r = ~(a ^ b); lgc = 1; end
      5'b11010: begin r = ~a;       lgc = 1; end
      5'b11011: begin r = ~a | b;   lgc = 1; end
      5'b11100: begin r = ~b;       lgc = 1; end
      5'b11101: begin r = a | ~b;   lgc = 1; end
      5'b11110: begin r = ~a | ~b;  lgc = 1; end
      5'b11111: r = '1;
      default:  r = '0;
    endcase
    if (arith) begin
      u   = longint'(a) + longint'(y) + longint'(cin);
      r   = W'(u);
      m_c = (u >> W) != 0;
      sv  = longint'($signed(a)) + longint'($signed(y)) + longint'(cin);
      m_o = (sv > 32767) || (sv < -32768);
    end
    if (arith || lgc) begin
      m_s = r[W-1];
      m_z = (r == 0);
    end
  endfunction

  // Issue one op, wait (bounded) for out_valid; reports latency and whether
  // in_ready stayed low while waiting.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] er,
                       output int exp_lat, output int lat, output bit busy_ok);
    model(op, a, b, er, exp_lat);
    @(negedge clk);
    in_valid = 1'b1; OP = op; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0; OP = 5'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; OP = 5'b00000; A = 16'h0001; B = 16'h0001;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    m_o = 0; m_c = 0; m_s = 0; m_z = 0;
    vectors++;
    if ({RESU, O, C, S, Z, out_valid, in_ready} !== {16'h0, 4'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got RESU=%h OCSZ=%b%b%b%b ov=%b rdy=%b, want 0 0000 0 1",
               RESU, O, C, S, Z, out_valid, in_ready);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_accept: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] er; int el, lat; bit bz;
    do_op(5'b00000, 16'h4800, 16'hE000, er, el, lat, bz);
    vectors++;
    if (lat !== 1 || {RESU, O, C, S, Z} !== {16'h2800, 4'b0100}) begin
      miscompares++;
      $display("FAIL add1: got lat=%0d RESU=%h OCSZ=%b%b%b%b, want 1 2800 0100",
               lat, RESU, O, C, S, Z);
    end
    do_op(5'b00000, 16'h7FFF, 16'h0001, er, el, lat, bz);
    vectors++;
    if (lat !== 1 || {RESU, O, C, S, Z} !== {16'h8000, 4'b1010}) begin
      miscompares++;
      $display("FAIL add_ovf: got lat=%0d RESU=%h OCSZ=%b%b%b%b, want 1 8000 1010",
               lat, RESU, O, C, S, Z);
    end
  endtask

  task automatic test_sub_hold();
    logic [W-1:0] er; int el, lat; bit bz;
    do_op(5'b00101, 16'h1234, 16'h1234, er, el, lat, bz);
    vectors++;
    if ({RESU, O, C, S, Z} !== {16'h0000, 4'b0101}) begin
      miscompares++;
      $display("FAIL sub_zero: got RESU=%h OCSZ=%b%b%b%b, want 0000 0101",
               RESU, O, C, S, Z);
    end
    do_op(5'b10011, 16'hFFFF, 16'h0000, er, el, lat, bz);
    vectors++;
    if ({RESU, O, C, S, Z} !== {16'h0000, 4'b0101}) begin
      miscompares++;
      $display("FAIL passb_hold: got RESU=%h OCSZ=%b%b%b%b, want 0000 0101",
               RESU, O, C, S, Z);
    end
  endtask

  task automatic test_lsl();
    logic [W-1:0] er; int el, lat; bit bz;
    logic o_before;
    o_before = O;
    do_op(5'b01000, 16'hC001, 16'h0003, er, el, lat, bz);
    vectors++;
    if (lat !== 4 || bz !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lsl_timing: got lat=%0d busy_ok=%b rdy=%b, want 4 1 1",
               lat, bz, in_ready);
    end
    vectors++;
    if ({RESU, O, C, S, Z} !== {16'h0008, o_before, 3'b000}) begin
      miscompares++;
      $display("FAIL lsl_result: got RESU=%h OCSZ=%b%b%b%b, want 0008 %b000",
               RESU, O, C, S, Z, o_before);
    end
  endtask

  task automatic test_asr_ignore();
    logic [W-1:0] er; int el, extra;
    model(5'b01001, 16'h8003, 16'h0002, er, el);
    @(negedge clk);
    in_valid = 1'b1; OP = 5'b01001; A = 16'h8003; B = 16'h0002;
    @(negedge clk);
    OP = 5'b10111; A = 16'h00FF; B = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL asr_early: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, RESU, C, S, Z} !== {1'b1, 16'hE000, 3'b110}) begin
      miscompares++;
      $display("FAIL asr_result: got ov=%b RESU=%h CSZ=%b%b%b, want 1 e000 110",
               out_valid, RESU, C, S, Z);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    vectors++;
    if (extra !== 0 || RESU !== 16'hE000) begin
      miscompares++;
      $display("FAIL asr_ignored: got extra_pulses=%0d RESU=%h, want 0 e000",
               extra, RESU);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]   ops [3];
    logic [W-1:0] er  [3];
    logic [3:0]   fl  [3];
    logic [W-1:0] a, b;
    int el;
    ops[0] = 5'b10001; ops[1] = 5'b10111; ops[2] = 5'b10110;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if ({out_valid, RESU, O, C, S, Z} !== {1'b1, er[i-1], fl[i-1]}) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got ov=%b RESU=%h OCSZ=%b%b%b%b, want 1 %h %b",
                   i - 1, out_valid, RESU, O, C, S, Z, er[i-1], fl[i-1]);
        end
      end
      if (i < 3) begin
        a = W'($urandom); b = W'($urandom);
        model(ops[i], a, b, er[i], el);
        fl[i] = {m_o, m_c, m_s, m_z};
        in_valid = 1'b1; OP = ops[i]; A = a; B = b;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_shift();
    logic [W-1:0] er; int el, lat; bit bz;
    int seen;
    do_op(5'b00000, 16'h7FFF, 16'h0001, er, el, lat, bz);
    model(5'b01000, 16'h0F0F, 16'h0005, er, el);
    @(negedge clk);
    in_valid = 1'b1; OP = 5'b01000; A = 16'h0F0F; B = 16'h0005;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid) seen++;
    @(negedge clk);
    if (out_valid) seen++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_o = 0; m_c = 0; m_s = 0; m_z = 0;
    vectors++;
    if ({out_valid, RESU, O, C, S, Z, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_shift: got ov=%b RESU=%h OCSZ=%b%b%b%b rdy=%b, want 0 0 0000 1",
               out_valid, RESU, O, C, S, Z, in_ready);
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rst_shift_abort: got %0d out_valid pulses want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [4:0] op; logic [W-1:0] a, b, er; int el, lat; bit bz;
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      a = W'($urandom);
      b = W'($urandom);
      if (n % 8 == 0) b[3:0] = 4'h0;
      do_op(op, a, b, er, el, lat, bz);
      vectors++;
      if (lat !== el || bz !== 1'b1 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_timing op=%b a=%h b=%h: got lat=%0d busy_ok=%b rdy=%b, want %0d 1 1",
                 op, a, b, lat, bz, in_ready, el);
      end
      vectors++;
      if ({RESU, O, C, S, Z} !== {er, m_o, m_c, m_s, m_z}) begin
        miscompares++;
        $display("FAIL rand_result op=%b a=%h b=%h: got %h %b%b%b%b, want %h %b%b%b%b",
                 op, a, b, RESU, O, C, S, Z, er, m_o, m_c, m_s, m_z);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; OP = '0; A = '0; B = '0;
    test_reset();
    test_add();
    test_sub_hold();
    test_lsl();
    test_asr_ignore();
    test_back_to_back();
    test_reset_in_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
